// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
// Round-robin arbiter and sequencer that shares one sequential multiplier
// engine among NREQ requesters. One job is in flight at a time. Operands
// are captured at the handshake. The engine product is returned unchanged
// on the owner's rsp_valid bit.
//
// Optional feature: define MUL_ARB_TIMEOUT_EN to abort a job after TIMEOUT
// WAIT cycles without mul_done. An aborted job responds with rsp_err=1 and
// rsp_p=0. Without the macro, WAIT holds until mul_done, rsp_err is tied low
// and no wait counter exists.
module mul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_p,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic                    mul_done,
  input  logic [2*WIDTH-1:0]      mul_p
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  if (NREQ < 2 || NREQ > 8 || WIDTH < 1 || TIMEOUT < 1) begin : g_param_check
    $error("mul_share_arbiter: unsupported parameter set");
  end

  // First requester with valid set, searching upward from ptr with wrap.
  // The MSB of the result flags that some requester was found.
  function automatic logic [PW:0] rr_pick(input logic [PW-1:0] ptr,
                                          input logic [NREQ-1:0] valid);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!res[PW] && valid[idx]) begin
        res = {1'b1, PW'(idx)};
      end
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] one_hot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  state_e                 state_q, state_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic [WIDTH-1:0]       op_a_q, op_a_d;
  logic [WIDTH-1:0]       op_b_q, op_b_d;
  logic [2*WIDTH-1:0]     result_q, result_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic                   mul_start_q, mul_start_d;
  logic [PW:0]            pick_s;
  logic                   grant_found_s;
  logic [PW-1:0]          grant_idx_s;
  logic [PW-1:0]          grant_next_s;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]          wait_cnt_q, wait_cnt_d;
  logic                   err_q, err_d;
`endif

  assign pick_s        = rr_pick(rr_ptr_q, req_valid);
  assign grant_found_s = pick_s[PW];
  assign grant_idx_s   = pick_s[PW-1:0];
  assign grant_next_s  = (grant_idx_s == PW'(NREQ - 1)) ? '0 : grant_idx_s + PW'(1);

  // Grant is only offered while idle; it depends on state, rr_ptr and req_valid.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found_s) begin
      req_ready = one_hot(grant_idx_s);
    end else begin
      req_ready = '0;
    end
  end

  // Next-state and next-register values for the sequencer.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    result_d    = result_q;
    rsp_valid_d = '0;
    mul_start_d = 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_found_s) begin
          owner_d     = grant_idx_s;
          op_a_d      = req_a[int'(grant_idx_s)*WIDTH +: WIDTH];
          op_b_d      = req_b[int'(grant_idx_s)*WIDTH +: WIDTH];
          rr_ptr_d    = grant_next_s;
          mul_start_d = 1'b1;
          state_d     = S_ISSUE;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (mul_done) begin
          result_d    = mul_p;
          rsp_valid_d = one_hot(owner_q);
          state_d     = S_RESP;
`ifdef MUL_ARB_TIMEOUT_EN
          err_d       = 1'b0;
`endif
        end else begin
`ifdef MUL_ARB_TIMEOUT_EN
          if (wait_cnt_q == CW'(TIMEOUT)) begin
            result_d    = '0;
            err_d       = 1'b1;
            rsp_valid_d = one_hot(owner_q);
            state_d     = S_RESP;
          end else begin
            wait_cnt_d  = wait_cnt_q + CW'(1);
            state_d     = S_WAIT;
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      rsp_valid_q <= '0;
      mul_start_q <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
      mul_start_q <= mul_start_d;
`ifdef MUL_ARB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mul_start = mul_start_q;
  assign mul_a     = op_a_q;
  assign mul_b     = op_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = result_q;
`ifdef MUL_ARB_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter. A behavioural engine model
// returns a*b after a programmable latency. A monitor keeps its own
// round-robin model, pushes the expected job at each handshake and pops it
// when the response appears.
module tb_mul_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int TMO  = 32;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_a;
  logic [NREQ*W-1:0]    req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [2*W-1:0]       rsp_p;
  logic                 rsp_err;
  logic                 busy;
  logic                 mul_start;
  logic [W-1:0]         mul_a;
  logic [W-1:0]         mul_b;
  logic                 mul_done;
  logic [2*W-1:0]       mul_p;

  mul_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_p(rsp_p), .rsp_err(rsp_err),
    .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_p(mul_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- engine model ----------------
  int           eng_lat  = 17;
  bit           eng_mute = 1'b0;
  int           rem      = 0;
  logic         eng_done = 1'b0;
  logic         spur_done;
  logic [W-1:0] ea = '0;
  logic [W-1:0] eb = '0;

  assign mul_done = eng_done | spur_done;
  assign mul_p    = {8'h00, ea} * {8'h00, eb};

  // engine: latch operands on start, raise done eng_lat cycles later
  always @(negedge clk) begin
    if (reset) begin
      rem      <= 0;
      eng_done <= 1'b0;
    end else if (mul_start && !eng_mute) begin
      rem      <= eng_lat;
      eng_done <= 1'b0;
      ea       <= mul_a;
      eb       <= mul_b;
    end else if (rem > 1) begin
      rem      <= rem - 1;
      eng_done <= 1'b0;
    end else if (rem == 1) begin
      rem      <= 0;
      eng_done <= 1'b1;
    end else begin
      eng_done <= 1'b0;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    int          owner;
    logic [15:0] p;
    logic        err;
    int          lat;
    int          hs;
  } job_t;

  job_t sb[$];
  int   grant_log[$];
  int   model_rr = 0;
  int   n_hs     = 0;
  int   n_rsp    = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_pick(input int ptr, input logic [NREQ-1:0] v);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // monitor: check grant/busy, push at handshake, pop and compare at response
  always @(negedge clk) begin
    int          g;
    logic [3:0]  exp_rdy;
    job_t        j;
    if (reset) begin
      model_rr = 0;
      sb.delete();
    end else begin
      g       = model_pick(model_rr, req_valid);
      exp_rdy = 4'b0000;
      if (sb.size() == 0 && g >= 0) exp_rdy[g] = 1'b1;
      check_eq("busy", 32'(busy), 32'(sb.size() != 0));
      check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (|(req_valid & req_ready) && g >= 0) begin
        j.owner = g;
        j.p     = eng_mute ? 16'h0000 : ({8'h00, req_a[g*W +: W]} * {8'h00, req_b[g*W +: W]});
        j.err   = eng_mute;
        j.lat   = eng_mute ? -1 : eng_lat;
        j.hs    = cyc;
        sb.push_back(j);
        grant_log.push_back(g);
        model_rr = (g + 1) % NREQ;
        n_hs++;
      end
      if (|rsp_valid) begin
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          j       = sb.pop_front();
          exp_rdy = 4'b0000;
          exp_rdy[j.owner] = 1'b1;
          check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rdy));
          check_eq("rsp_p", 32'(rsp_p), 32'(j.p));
          check_eq("rsp_err", 32'(rsp_err), 32'(j.err));
          if (j.lat >= 0) check_eq("latency", 32'(cyc - j.hs), 32'(j.lat + 2));
        end
        n_rsp++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(input int idx, input logic [7:0] a, input logic [7:0] b);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_valid[idx]    = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      #2;
      if (req_ready[idx]) begin
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      req_valid[idx] = 1'b0;
      check_eq("hs_timeout", 32'(got), 32'd1);
    end
  endtask

  task automatic wait_rsp(input int target, input int bound);
    for (int i = 0; i < bound && n_rsp < target; i++) begin
      @(posedge clk); #1;
    end
    check_eq("rsp_count", 32'(n_rsp), 32'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rsp_p"},     32'(rsp_p),     32'd0);
    check_eq({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    check_eq({tag, "_busy"},      32'(busy),      32'd0);
    check_eq({tag, "_mul_start"}, 32'(mul_start), 32'd0);
    check_eq({tag, "_mul_a"},     32'(mul_a),     32'd0);
    check_eq({tag, "_mul_b"},     32'(mul_b),     32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base_hs;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    spur_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    reset = 1'b0;

    // single job: 3*5, engine 17 cycles, response 19 cycles after handshake
    eng_lat = 17;
    do_req(0, 8'h03, 8'h05);
    #1;
    check_eq("start_pulse", 32'(mul_start), 32'd1);
    check_eq("issue_mul_a", 32'(mul_a), 32'h03);
    check_eq("issue_mul_b", 32'(mul_b), 32'h05);
    @(posedge clk); #1;
    check_eq("start_one_cycle", 32'(mul_start), 32'd0);
    wait_rsp(1, 100);

    // operand isolation: requester changes req_a after handshake
    eng_lat = 5;
    do_req(2, 8'h7F, 8'h03);
    req_a[2*W +: W] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("iso_mul_a", 32'(mul_a), 32'h7F);
      check_eq("iso_mul_b", 32'(mul_b), 32'h03);
    end
    wait_rsp(2, 100);

    // spurious done while idle, then while in ISSUE
    @(posedge clk); #1;
    spur_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    spur_done = 1'b0;
    eng_lat = 6;
    do_req(1, 8'hC8, 8'h0B);
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    wait_rsp(3, 100);

    // reset five cycles into the job: everything clears, no response
    eng_lat = 20;
    do_req(3, 8'hA5, 8'h5A);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_eq("no_rsp_after_reset", 32'(n_rsp), 32'd3);

    // round robin: all requesters held valid, expect 0,1,2,3,0
    eng_lat = 4;
    grant_log.delete();
    base_hs = n_hs;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = 8'(8'h11 * (i + 1) + 8'h02);
      req_b[i*W +: W] = 8'(8'h20 + i);
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 300 && n_hs < base_hs + 5; i++) begin
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;
    check_eq("rr_handshakes", 32'(n_hs - base_hs), 32'd5);
    wait_rsp(8, 100);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) check_eq("rr_order", 32'(grant_log[i]), 32'(exp_order[i]));
      else check_eq("rr_order_missing", 32'(grant_log.size()), 32'd5);
    end

`ifdef MUL_ARB_TIMEOUT_EN
    // engine never answers: abort with rsp_err=1, rsp_p=0; late done ignored
    eng_mute = 1'b1;
    do_req(0, 8'h12, 8'h34);
    wait_rsp(9, TMO + 40);
    eng_mute = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("late_done_ignored", 32'(n_rsp), 32'd9);
`endif

    repeat (5) @(posedge clk);
    #1;
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one sequential 8-bit multiplier engine among NREQ requesters. It accepts operand pairs from requesters, issues one job at a time to the engine, waits for engine completion, and returns the 16-bit product to the granted requester. It sits between the client blocks and the multiplier engine; the engine's internal algorithm and latency are opaque to it.

## Interface

- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: operand width; product width is 2*WIDTH.
- TIMEOUT, 32: maximum WAIT cycles before abort (used only with MUL_ARB_TIMEOUT_EN).

- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester job request.
- req_ready  out  NREQ  one-hot grant/accept; handshake when valid&ready.
- req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- rsp_valid  out  NREQ  one-hot, one-cycle result strobe.
- rsp_p  out  2*WIDTH  product, valid when any rsp_valid bit set.
- rsp_err  out  1  job aborted by timeout, qualified by rsp_valid.
- busy  out  1  high in any state other than IDLE.
- mul_start  out  1  one-cycle start pulse to engine.
- mul_a, mul_b  out  WIDTH  operands to engine, stable from ISSUE until the following IDLE.
- mul_done  in  1  engine completion strobe.
- mul_p  in  2*WIDTH  engine product, valid with mul_done.

## Operation

- States: IDLE, ISSUE, WAIT, RESP. Reset state IDLE.
- IDLE: grant g = first i with req_valid[i], searching from rr_ptr upward modulo NREQ. req_ready[g]=1 combinationally, all other bits 0. On handshake: capture req_a/req_b slice g into operand registers, register g as owner, rr_ptr <= (g+1) mod NREQ, go ISSUE. No request: stay IDLE, req_ready=0.
- req_ready is 0 in every state except IDLE.
- ISSUE: mul_start=1 for exactly this cycle; go WAIT; clear wait counter.
- WAIT: mul_done=1 -> capture mul_p into result register, err=0, go RESP. Otherwise increment wait counter.
- RESP: rsp_valid[owner]=1 for one cycle, rsp_p=result, rsp_err=err; go IDLE.
- mul_done outside WAIT is ignored.
- Requester changing req_a/req_b after handshake has no effect on the in-flight job.
- Arbiter performs no arithmetic; it passes the engine product through unchanged.
- Reset mid-job (any state): immediate return to IDLE, rr_ptr=0, in-flight job dropped, no rsp_valid issued.
- Reset values: req_ready=0, rsp_valid=0, rsp_p=0, rsp_err=0, busy=0, mul_start=0, mul_a=0, mul_b=0; rr_ptr=0, wait counter=0.

## Timing

- Handshake in cycle T; mul_start in T+1; engine done at cycle D (D >= T+2); rsp_valid at D+1; next grant possible at D+2.
- Total latency from handshake to rsp_valid = engine latency + 2 cycles.
- rsp_valid, rsp_p, rsp_err, mul_start, mul_a and mul_b are registered outputs; req_ready is combinational from state, rr_ptr and req_valid.
- Back-to-back jobs: one idle cycle (the IDLE grant cycle) between RESP and the next ISSUE.

## Configuration

- MUL_ARB_TIMEOUT_EN defined: in WAIT, when the wait counter reaches TIMEOUT without mul_done, go RESP with rsp_p=0, rsp_err=1. A mul_done arriving in that same cycle wins (normal completion, rsp_err=0). Late engine done is ignored.
- Not defined: WAIT holds indefinitely until mul_done; rsp_err tied 0; no wait counter is built.

## Test plan

- Single job: requester 0, a=8'h03, b=8'h05; engine model returns 16'h000F after 17 cycles -> rsp_valid=4'b0001, rsp_p=16'h000F, rsp_err=0, exactly 19 cycles after handshake.
- Round-robin: all four req_valid held high -> grants in order 0,1,2,3,0; each requester receives its own product on its rsp_valid bit.
- Operand isolation: requester 2 changes req_a from 8'h7F to 8'h01 right after its handshake -> mul_a stays 8'h7F, product matches 8'h7F operands.
- Spurious done: mul_done pulsed during IDLE and ISSUE -> no rsp_valid, FSM unaffected.
- Reset mid-WAIT: assert reset 5 cycles after mul_start -> all outputs 0, busy=0 immediately, no response; next grant starts from requester 0.
- With MUL_ARB_TIMEOUT_EN, TIMEOUT=32, engine never asserts done -> rsp_valid to owner with rsp_err=1, rsp_p=16'h0000; a later mul_done is ignored.
